// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a requester and the
// bit-serial adder controller.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: drives operands and the start request.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side: consumes operands, reports status and result.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder reused across WIDTH bits,
// LSB first, one bit per clock, bracketed by a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [CW-1:0]    cnt_reg;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // The single shared full adder, fed by the operand LSBs and carry.
    assign sum_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign carry_next = (a_sr_reg[0] & b_sr_reg[0]) |
                        ((a_sr_reg[0] ^ b_sr_reg[0]) & carry_reg);

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = sum_bit;
        end else begin : g_res_wn
            assign res_next = {sum_bit, res_sr_reg[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_reg   <= bus.a;
                        b_sr_reg   <= bus.b;
                        carry_reg  <= bus.cin;
                        res_sr_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    res_sr_reg <= res_next;
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    carry_reg  <= carry_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        // Result is published only here, so sum/cout hold
                        // steady through any later RUN.
                        sum_reg   <= res_next;
                        cout_reg  <= carry_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: three adder instances (WIDTH 1, 8, 32) with a
// scoreboard queue per instance, a vector table and hand-written sequences.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(1))  if1 ();
    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(32)) if32 ();

    serial_adder_ctrl #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder_ctrl #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    int n_cmp = 0;
    int n_bad = 0;
    int dcnt8 = 0;

    logic [32:0] q1[$];
    logic [32:0] q8[$];
    logic [32:0] q32[$];

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout,sum} = a + b + cin within w bits.
    function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c};
    endfunction

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s);
        case (w)
            1:       begin if1.a = a[0];    if1.b = b[0];    if1.cin = c;  if1.start = s;  end
            8:       begin if8.a = a[7:0];  if8.b = b[7:0];  if8.cin = c;  if8.start = s;  end
            default: begin if32.a = a;      if32.b = b;      if32.cin = c; if32.start = s; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            1:       return if1.done;
            8:       return if8.done;
            default: return if32.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return if1.busy;
            8:       return if8.busy;
            default: return if32.busy;
        endcase
    endfunction

    task automatic push_exp(input int w, input logic [32:0] e);
        case (w)
            1:       q1.push_back(e);
            8:       q8.push_back(e);
            default: q32.push_back(e);
        endcase
    endtask

    // One start pulse, expectation queued; checks latency and returns in IDLE.
    task automatic do_add(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [32:0] e);
        int lat;
        drive(w, a, b, c, 1'b1);
        push_exp(w, e);
        tick();
        drive(w, a, b, c, 1'b0);
        chk($sformatf("busy_after_start_w%0d", w), 64'(get_busy(w)), 64'd1);
        lat = 0;
        while (!get_done(w) && lat < w + 4) begin
            tick();
            lat++;
        end
        chk($sformatf("latency_w%0d", w), 64'(lat), 64'(w));
        chk($sformatf("busy_at_done_w%0d", w), 64'(get_busy(w)), 64'd0);
        tick();
    endtask

    // Scoreboard monitors: pop and compare on each done pulse.
    always @(negedge clk) begin
        if (if1.done) begin
            if (q1.size() == 0) chk("spurious_done_w1", 64'(if1.done), 64'd0);
            else chk("result_w1", 64'({if1.cout, if1.sum}), 64'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (if8.done) begin
            dcnt8++;
            if (q8.size() == 0) chk("spurious_done_w8", 64'(if8.done), 64'd0);
            else chk("result_w8", 64'({if8.cout, if8.sum}), 64'(q8.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (if32.done) begin
            if (q32.size() == 0) chk("spurious_done_w32", 64'(if32.done), 64'd0);
            else chk("result_w32", 64'({if32.cout, if32.sum}), 64'(q32.pop_front()));
        end
    end

    initial begin
        int d0;
        int t1;
        int t2;
        int n;

        // Reset with random inputs applied.
        rst_n = 1'b0;
        drive(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
        drive(8, $urandom, $urandom, 1'($urandom), 1'($urandom));
        drive(32, $urandom, $urandom, 1'($urandom), 1'($urandom));
        repeat (3) tick();
        drive(1, 0, 0, 1'b0, 1'b0);
        drive(8, 0, 0, 1'b0, 1'b0);
        drive(32, 0, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("reset_w8", 64'({if8.busy, if8.done, if8.cout, if8.sum}), 64'd0);
        chk("reset_w1", 64'({if1.busy, if1.done, if1.cout, if1.sum}), 64'd0);
        chk("reset_w32", 64'({if32.busy, if32.done, if32.cout, if32.sum}), 64'd0);

        // Idle hold: outputs must not move without start.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle_w8_c%0d", i), 64'({if8.busy, if8.done, if8.cout, if8.sum}), 64'd0);
        end

        // Vector table: WIDTH=8 directed sums, then all WIDTH=1 combinations.
        tbl.push_back('{8, 32'hFF, 32'h01, 1'b0, 33'h100});
        tbl.push_back('{8, 32'hA5, 32'h5A, 1'b1, 33'h100});
        tbl.push_back('{8, 32'h7F, 32'h01, 1'b0, 33'h080});
        tbl.push_back('{1, 32'd0, 32'd0, 1'b0, 33'd0});
        tbl.push_back('{1, 32'd0, 32'd0, 1'b1, 33'd1});
        tbl.push_back('{1, 32'd0, 32'd1, 1'b0, 33'd1});
        tbl.push_back('{1, 32'd0, 32'd1, 1'b1, 33'd2});
        tbl.push_back('{1, 32'd1, 32'd0, 1'b0, 33'd1});
        tbl.push_back('{1, 32'd1, 32'd0, 1'b1, 33'd2});
        tbl.push_back('{1, 32'd1, 32'd1, 1'b0, 33'd2});
        tbl.push_back('{1, 32'd1, 32'd1, 1'b1, 33'd3});
        for (int i = 0; i < tbl.size(); i++)
            do_add(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);

        // Ignored start in RUN and DONE, operands churning after capture.
        d0 = dcnt8;
        drive(8, 32'h03, 32'h04, 1'b0, 1'b1);
        q8.push_back(33'h007);
        tick();
        for (int i = 1; i <= 9; i++) begin
            drive(8, $urandom, $urandom, 1'($urandom), (i == 3) || (i == 9));
            if (i == 3) drive(8, 32'hFF, 32'hFF, 1'b0, 1'b1);
            tick();
            if (i < 8) chk($sformatf("sum_stable_run_c%0d", i), 64'({if8.cout, if8.sum}), 64'h080);
        end
        drive(8, 0, 0, 1'b0, 1'b0);
        repeat (4) tick();
        chk("no_second_add_busy", 64'(if8.busy), 64'd0);
        chk("single_done_pulse", 64'(dcnt8 - d0), 64'd1);

        // Asynchronous reset in the middle of RUN.
        d0 = dcnt8;
        drive(8, 32'hFF, 32'hFF, 1'b1, 1'b1);
        tick();
        drive(8, 32'hFF, 32'hFF, 1'b1, 1'b0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", 64'({if8.busy, if8.done, if8.cout, if8.sum}), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        repeat (12) tick();
        chk("midrun_reset_no_done", 64'(dcnt8 - d0), 64'd0);
        do_add(8, 32'h10, 32'h20, 1'b0, 33'h030);

        // Back-to-back with start held high.
        drive(8, 32'h01, 32'h01, 1'b0, 1'b1);
        q8.push_back(33'h002);
        t1 = -1;
        t2 = -1;
        n = 0;
        while (t2 < 0 && n < 40) begin
            tick();
            n++;
            if (if8.done) begin
                if (t1 < 0) begin
                    t1 = n;
                    drive(8, 32'h80, 32'h80, 1'b0, 1'b1);
                    q8.push_back(33'h100);
                end else begin
                    t2 = n;
                end
            end
        end
        drive(8, 0, 0, 1'b0, 1'b0);
        chk("b2b_done_spacing", 64'(t2 - t1), 64'd10);
        repeat (3) tick();

        // Random regression on WIDTH=8 and WIDTH=32 in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [31:0] ra, rb;
                    logic rc;
                    ra = $urandom; rb = $urandom; rc = 1'($urandom);
                    do_add(8, ra, rb, rc, model(8, ra, rb, rc));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [31:0] ra, rb;
                    logic rc;
                    ra = $urandom; rb = $urandom; rc = 1'($urandom);
                    do_add(32, ra, rb, rc, model(32, ra, rb, rc));
                end
            end
        join
        repeat (3) tick();

        chk("queue_empty_w1", 64'(q1.size()), 64'd0);
        chk("queue_empty_w8", 64'(q8.size()), 64'd0);
        chk("queue_empty_w32", 64'(q32.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
